// File: rtl/wall_engine.sv
// wall_engine: per-lane radial wall shift registers fed from per-mode pattern banks.
// Latency: state moves 1 cycle after an accepted step, is_wall is combinational; no backpressure, invalid steps are dropped.
module wall_engine #(
  parameter int LANES          = 6,
  parameter int DEPTH          = 400,
  parameter int PAT_LEN        = 64,
  parameter int HOLD_LOG2      = 5,
  parameter int MODES          = 3,
  parameter int SCORE_W        = 13,
  parameter int SCORE_DIV_LOG2 = 5,
  localparam int LW  = $clog2(LANES),
  localparam int LW1 = LW + 1,
  localparam int RW  = $clog2(DEPTH),
  localparam int PW  = $clog2(PAT_LEN),
  localparam int CW  = SCORE_W + SCORE_DIV_LOG2
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               step,
  input  logic               clear,
  input  logic [1:0]         mode,
  input  logic [LW-1:0]      rot,
  input  logic               pat_we,
  input  logic [1:0]         pat_mode,
  input  logic [PW-1:0]      pat_addr,
  input  logic [LANES-1:0]   pat_data,
  input  logic [LW-1:0]      lane,
  input  logic [RW-1:0]      radius,
  output logic               is_wall,
  output logic [SCORE_W-1:0] Score,
  output logic [PW-1:0]      pat_index,
  output logic               pat_wrap
);

  logic [LANES-1:0]     pat_mem [1:MODES][PAT_LEN];
  logic [DEPTH-1:0]     walls [LANES];
  logic [HOLD_LOG2-1:0] sub_cnt;
  logic [CW-1:0]        step_cnt;
  logic                 run_en;
  logic                 mode_ok;
  logic                 accept;
  logic [LW-1:0]        rot_eff;
  logic [LANES-1:0]     cur_row;
  logic [LANES-1:0]     inj;
  logic [LW:0]          sum;

  // Single stage on purpose: the first step after release lands on the second edge.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) run_en <= 1'b0;
    else          run_en <= 1'b1;
  end

  assign mode_ok = (mode != 2'd0) && (int'(mode) <= MODES);
  assign accept  = run_en && step && !clear && mode_ok;
  assign rot_eff = (int'(rot) >= LANES) ? '0 : rot;
  assign cur_row = mode_ok ? pat_mem[mode][pat_index] : '0;

  always_comb begin
    inj = '0;
    sum = '0;
    for (int l = 0; l < LANES; l++) begin
      sum = {1'b0, rot_eff} + LW1'(l);
      if (sum >= LW1'(LANES)) sum = sum - LW1'(LANES);
      inj[l] = cur_row[sum[LW-1:0]];
    end
  end

  // Not reset: pattern banks survive both Reset_n and clear.
  always_ff @(posedge Clk) begin
    if (pat_we && pat_mode != 2'd0 && int'(pat_mode) <= MODES)
      pat_mem[pat_mode][pat_addr] <= pat_data;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int l = 0; l < LANES; l++) walls[l] <= '0;
    end else if (clear) begin
      for (int l = 0; l < LANES; l++) walls[l] <= '0;
    end else if (accept) begin
      for (int l = 0; l < LANES; l++) walls[l] <= {inj[l], walls[l][DEPTH-1:1]};
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sub_cnt   <= '0;
      pat_index <= '0;
      step_cnt  <= '0;
      pat_wrap  <= 1'b0;
    end else if (clear) begin
      sub_cnt   <= '0;
      pat_index <= '0;
      step_cnt  <= '0;
      pat_wrap  <= 1'b0;
    end else begin
      pat_wrap <= 1'b0;
      if (accept) begin
        sub_cnt <= sub_cnt + 1'b1;
        if (&sub_cnt) begin
          pat_index <= pat_index + 1'b1;
          pat_wrap  <= (pat_index == PW'(PAT_LEN - 1));
        end
        if (!(&step_cnt)) step_cnt <= step_cnt + 1'b1;
      end
    end
  end

  assign Score   = step_cnt[CW-1:SCORE_DIV_LOG2];
  assign is_wall = (int'(lane) < LANES && int'(radius) < DEPTH) ? walls[lane][radius] : 1'b0;

endmodule

// File: tb/tb_wall_engine.sv
// Bench for wall_engine: vector table with a scoreboard queue, then hand-written multi-cycle sequences.
// Inputs change on the falling edge; outputs are sampled in the low phase, away from the rising edge.
module tb_wall_engine;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        step = 1'b0;
  logic        clear = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [2:0]  rot = 3'd0;
  logic        pat_we = 1'b0;
  logic [1:0]  pat_mode = 2'd0;
  logic [5:0]  pat_addr = 6'd0;
  logic [5:0]  pat_data = 6'd0;
  logic [2:0]  lane = 3'd0;
  logic [8:0]  radius = 9'd0;
  logic        is_wall;
  logic [12:0] Score;
  logic [5:0]  pat_index;
  logic        pat_wrap;

  wall_engine dut (
    .Clk(Clk), .Reset_n(Reset_n), .step(step), .clear(clear), .mode(mode), .rot(rot),
    .pat_we(pat_we), .pat_mode(pat_mode), .pat_addr(pat_addr), .pat_data(pat_data),
    .lane(lane), .radius(radius), .is_wall(is_wall), .Score(Score),
    .pat_index(pat_index), .pat_wrap(pat_wrap)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;
  int wrap_seen = 0;

  always @(negedge Clk) if (pat_wrap === 1'b1) wrap_seen++;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int         n;
    logic [1:0] m;
    logic [2:0] r;
    logic       clr;
    logic [2:0] ql;
    logic [8:0] qr;
    logic       ew;
    int         es;
    int         ei;
  } vec_t;

  typedef struct {
    logic w;
    int   s;
    int   i;
  } exp_t;

  vec_t vt[16];
  exp_t exp_q[$];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, got, expv);
    end
  endtask

  task automatic look(input int l, input int r);
    lane = 3'(l);
    radius = 9'(r);
    #1;
  endtask

  task automatic run_steps(input int n);
    if (n > 0) begin
      step = 1'b1;
      repeat (n) @(posedge Clk);
      @(negedge Clk);
      step = 1'b0;
      clear = 1'b0;
    end
  endtask

  task automatic write_row(input int b, input int a, input logic [5:0] d);
    pat_we = 1'b1;
    pat_mode = 2'(b);
    pat_addr = 6'(a);
    pat_data = d;
    @(negedge Clk);
    pat_we = 1'b0;
  endtask

  task automatic count_walls(output int c);
    c = 0;
    for (int l = 0; l < 6; l++)
      for (int r = 0; r < 400; r++) begin
        lane = 3'(l);
        radius = 9'(r);
        #1;
        if (is_wall === 1'b1) c++;
      end
    @(negedge Clk);
  endtask

  initial begin
    int   cnt;
    int   wbase;
    exp_t e;
    logic [17:0] near_max;

    vt[0]  = '{0,  2'd1, 3'd0, 1'b0, 3'd0, 9'd399, 1'b0, 0, 0};
    vt[1]  = '{1,  2'd1, 3'd2, 1'b0, 3'd4, 9'd399, 1'b1, 0, 0};
    vt[2]  = '{0,  2'd1, 3'd2, 1'b0, 3'd0, 9'd399, 1'b0, 0, 0};
    vt[3]  = '{1,  2'd1, 3'd7, 1'b0, 3'd0, 9'd399, 1'b1, 0, 0};
    vt[4]  = '{0,  2'd1, 3'd7, 1'b0, 3'd4, 9'd398, 1'b1, 0, 0};
    vt[5]  = '{0,  2'd1, 3'd7, 1'b0, 3'd4, 9'd399, 1'b0, 0, 0};
    vt[6]  = '{1,  2'd0, 3'd0, 1'b0, 3'd0, 9'd399, 1'b1, 0, 0};
    vt[7]  = '{0,  2'd0, 3'd0, 1'b0, 3'd4, 9'd398, 1'b1, 0, 0};
    vt[8]  = '{0,  2'd0, 3'd0, 1'b0, 3'd6, 9'd399, 1'b0, 0, 0};
    vt[9]  = '{1,  2'd2, 3'd0, 1'b0, 3'd4, 9'd399, 1'b1, 0, 0};
    vt[10] = '{0,  2'd2, 3'd0, 1'b0, 3'd0, 9'd399, 1'b0, 0, 0};
    vt[11] = '{0,  2'd2, 3'd0, 1'b0, 3'd0, 9'd398, 1'b1, 0, 0};
    vt[12] = '{28, 2'd1, 3'd0, 1'b0, 3'd0, 9'd399, 1'b1, 0, 0};
    vt[13] = '{1,  2'd1, 3'd0, 1'b0, 3'd0, 9'd399, 1'b1, 1, 1};
    vt[14] = '{1,  2'd1, 3'd0, 1'b0, 3'd0, 9'd399, 1'b0, 1, 1};
    vt[15] = '{1,  2'd1, 3'd0, 1'b1, 3'd0, 9'd397, 1'b0, 0, 0};

    // Load every row so nothing depends on power-up memory contents.
    @(negedge Clk);
    for (int b = 1; b <= 3; b++)
      for (int a = 0; a < 64; a++)
        write_row(b, a, (b == 1 && a == 0) ? 6'b000001 : (b == 2 && a == 0) ? 6'b010000 : 6'b000000);
    look(0, 399);
    chk("rst_score", Score, 0);
    chk("rst_index", pat_index, 0);
    chk("rst_wrap", pat_wrap, 0);
    chk("rst_wall", is_wall, 0);
    @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);
    @(negedge Clk);

    for (int i = 0; i < 16; i++) begin
      mode = vt[i].m;
      rot = vt[i].r;
      clear = vt[i].clr;
      exp_q.push_back('{vt[i].ew, vt[i].es, vt[i].ei});
      run_steps(vt[i].n);
      look(int'(vt[i].ql), int'(vt[i].qr));
      e = exp_q.pop_front();
      chk($sformatf("v%0d_wall", i), is_wall, e.w);
      chk($sformatf("v%0d_score", i), Score, e.s);
      chk($sformatf("v%0d_index", i), pat_index, e.i);
    end
    count_walls(cnt);
    chk("clear_empty", cnt, 0);

    // Injection with a same-cycle overwrite of the row being injected.
    mode = 2'd1; rot = 3'd0; step = 1'b1;
    pat_we = 1'b1; pat_mode = 2'd1; pat_addr = 6'd0; pat_data = 6'd0;
    @(negedge Clk);
    step = 1'b0; pat_we = 1'b0;
    look(0, 399);
    chk("inj_top", is_wall, 1);
    count_walls(cnt);
    chk("inj_count", cnt, 1);
    run_steps(399);
    look(0, 0);
    chk("inj_bottom", is_wall, 1);
    count_walls(cnt);
    chk("inj_count2", cnt, 1);
    run_steps(1);
    count_walls(cnt);
    chk("inj_gone", cnt, 0);
    write_row(1, 0, 6'b000001);

    // Row advance and wrap from reset.
    Reset_n = 1'b0;
    @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);
    @(negedge Clk);
    wbase = wrap_seen;
    run_steps(32);
    chk("idx_after32", pat_index, 1);
    run_steps(2015);
    chk("idx_after2047", pat_index, 63);
    chk("wrap_none_yet", wrap_seen - wbase, 0);
    run_steps(1);
    chk("wrap_pulse", pat_wrap, 1);
    chk("idx_wrapped", pat_index, 0);
    chk("score_2048", Score, 64);
    @(negedge Clk);
    chk("wrap_low", pat_wrap, 0);
    repeat (3) @(negedge Clk);
    chk("wrap_once", wrap_seen - wbase, 1);

    // Saturation of the step counter.
    near_max = 18'h3FFFD;
    force dut.step_cnt = near_max;
    #1;
    release dut.step_cnt;
    @(negedge Clk);
    run_steps(2);
    chk("sat_score", Score, 8191);
    run_steps(3);
    chk("sat_hold", Score, 8191);

    // Asynchronous reset mid-run, then the first step after release.
    clear = 1'b1;
    @(negedge Clk);
    clear = 1'b0;
    mode = 2'd1; rot = 3'd0;
    run_steps(100);
    look(0, 300);
    chk("run_wall", is_wall, 1);
    chk("run_score", Score, 3);
    chk("run_index", pat_index, 3);
    #2;
    Reset_n = 1'b0;
    #1;
    chk("arst_wall", is_wall, 0);
    chk("arst_score", Score, 0);
    chk("arst_index", pat_index, 0);
    chk("arst_wrap", pat_wrap, 0);
    count_walls(cnt);
    chk("arst_empty", cnt, 0);
    step = 1'b1;
    Reset_n = 1'b1;
    @(negedge Clk);
    @(negedge Clk);
    step = 1'b0;
    look(0, 399);
    chk("post_rst_top", is_wall, 1);
    look(0, 398);
    chk("post_rst_single", is_wall, 0);
    chk("post_rst_score", Score, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
